uart_rx_frame_chk: RTL and testbench
====================================

# uart_rx_frame_chk

Parametrised UART receive-frame checker sitting between the RX data sampler and the RX control FSM. It consumes one sampled bit per bit period and walks the whole frame: start, DATA_WIDTH data bits LSB first, optional parity, and STOP_BITS stop bits. It reports a start glitch, a parity error and a stop error per frame, and delivers the deserialised word with a valid pulse. It also keeps a saturating count of erroneous frames for the register file.

## Interface
- DATA_WIDTH, 8: data bits per frame, 5..9.
- STOP_BITS, 1: stop bits checked, 1 or 2.
- CNT_WIDTH, 8: width of the error-frame counter.

- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse from the RX FSM on detected falling edge of the line.
- bit_valid  in  1  one-cycle strobe: sampled_bit holds the mid-bit majority sample.
- sampled_bit  in  1  sampled line value, qualified by bit_valid.
- par_en  in  1  parity bit present; latched at frame_start.
- par_typ  in  1  0 = even, 1 = odd; latched at frame_start.
- err_clr  in  1  synchronous clear of err_cnt.
- frame_busy  out  1  high from the cycle after accepted frame_start until frame end or abort.
- strt_glitch  out  1  one-cycle pulse: start bit sampled as 1.
- par_err  out  1  one-cycle pulse at frame end: parity mismatch.
- stp_err  out  1  one-cycle pulse at frame end: any stop bit sampled as 0.
- data_out  out  DATA_WIDTH  last received word; updated only on good frames.
- data_valid  out  1  one-cycle pulse: good frame, data_out updated.
- err_cnt  out  CNT_WIDTH  saturating count of frames with any error, including glitches.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Transitions advance only on bit_valid, except the IDLE to START transition.
- IDLE: frame_start moves the block to START and latches par_en and par_typ. bit_valid is ignored in IDLE.
- START: on bit_valid with sampled_bit=1, pulse strt_glitch, increment err_cnt and return to IDLE. On bit_valid with sampled_bit=0, go to DATA and clear bit_cnt and the parity accumulator.
- DATA: each bit_valid shifts sampled_bit in at the MSB and shifts right, so the LSB arrives first. The bit is also XORed into the accumulator. After DATA_WIDTH bits, go to PARITY if the latched par_en is set, otherwise go to STOP.
- PARITY: the expected bit is the accumulator XOR the latched par_typ. A mismatch sets an internal per-frame parity flag. The next state is STOP.
- STOP: each bit_valid with sampled_bit=0 sets an internal stop flag. After STOP_BITS bits, go to IDLE and issue the end-of-frame outputs:
  - par_err is the parity flag; stp_err is the stop flag.
  - If neither flag is set, data_out takes the shift register and data_valid is pulsed.
  - If either flag is set, err_cnt increments and data_out holds its previous value.
- err_cnt saturates at 2^CNT_WIDTH−1. err_clr has priority over a same-cycle increment, so the result is 0.
- frame_start while not in IDLE is ignored; it does not restart the frame.
- frame_start and bit_valid in the same IDLE cycle: frame_start is accepted and that bit_valid is discarded.
- bit_cnt is $clog2(DATA_WIDTH+1) bits wide. bit_cnt also counts stop bits and is cleared on each state entry.

## Timing
- Reset values: state IDLE; frame_busy, strt_glitch, par_err, stp_err and data_valid are 0; data_out is 0; err_cnt is 0. Internal flags, the shift register and bit_cnt are also 0.
- RST asserted mid-frame aborts immediately with no error pulse and no err_cnt change.
- All outputs are registered.
- strt_glitch is asserted in the cycle after the start-bit bit_valid.
- par_err, stp_err and data_valid are asserted together in the cycle after the final stop-bit bit_valid. They are 0 in every other cycle.
- frame_busy:
  - Rises the cycle after frame_start.
  - Falls in the same cycle that the end pulses or the glitch pulse assert.
  - Consequently a new frame_start is accepted in the cycle the end pulse is visible.
- err_cnt updates in the same cycle as the error pulse.
- Back-to-back bit_valid on consecutive cycles is legal and must not lose bits.

## Test plan
- DATA_WIDTH=8, par_en=1, par_typ=0. Frame 0xA5: start 0, data bits LSB first 1,0,1,0,0,1,0,1, parity 0, stop 1. Required: data_out=0xA5, one data_valid pulse, no error pulses, err_cnt=0.
- Same frame with par_typ=1 and parity bit 0 -> par_err pulse, no data_valid, data_out unchanged, err_cnt=1.
- Start bit sampled as 1 -> strt_glitch pulse the next cycle, frame_busy drops, err_cnt increments. A frame_start in that same cycle is accepted.
- STOP_BITS=2, second stop bit 0, par_en=0, data 0x3C -> stp_err pulse only, no data_valid, err_cnt increments.
- err_cnt=255 (CNT_WIDTH=8) plus another bad frame -> stays 255. Asserting err_clr in the same cycle as an error pulse -> 0.
- RST asserted after 4 data bits -> all outputs 0 immediately. A following clean frame 0x5A -> data_valid pulse with data_out=0x5A.

Source files
------------

// File: rtl/uart_rx_frame_chk.sv
// UART receive-frame checker: walks start, data (LSB first), optional parity and stop bits,
// flags start glitches, parity and stop errors, and keeps a saturating error-frame count.
module uart_rx_frame_chk #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  frame_start,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  err_clr,
  output logic                  frame_busy,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stp_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_acc;
  logic                  par_flag;
  logic                  stp_flag;
  logic                  last_stop;
  logic                  err_event;

  // Decoded frame-level events shared by the FSM and the error counter.
  always_comb begin
    last_stop = (state == STOP) && bit_valid && (bit_cnt == LAST_STOP);
    err_event = ((state == START) && bit_valid && sampled_bit) ||
                (last_stop && (par_flag || stp_flag || !sampled_bit));
  end

  // NOTE: all state updates use <= so every branch sees the pre-edge values of the registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      par_acc     <= 1'b0;
      par_flag    <= 1'b0;
      stp_flag    <= 1'b0;
      frame_busy  <= 1'b0;
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
    end else begin
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      data_valid  <= 1'b0;

      case (state)
        IDLE: begin
          // A bit_valid coinciding with frame_start belongs to no frame and is dropped.
          if (frame_start) begin
            state      <= START;
            par_en_q   <= par_en;
            par_typ_q  <= par_typ;
            bit_cnt    <= '0;
            par_flag   <= 1'b0;
            stp_flag   <= 1'b0;
            frame_busy <= 1'b1;
          end
        end

        START: begin
          if (bit_valid) begin
            if (sampled_bit) begin
              state       <= IDLE;
              strt_glitch <= 1'b1;
              frame_busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
              par_acc <= 1'b0;
            end
          end
        end

        DATA: begin
          if (bit_valid) begin
            shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
            par_acc   <= par_acc ^ sampled_bit;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end

        PARITY: begin
          if (bit_valid) begin
            if (sampled_bit != (par_acc ^ par_typ_q)) par_flag <= 1'b1;
            bit_cnt <= '0;
            state   <= STOP;
          end
        end

        STOP: begin
          if (bit_valid) begin
            if (!sampled_bit) stp_flag <= 1'b1;
            if (last_stop) begin
              state      <= IDLE;
              bit_cnt    <= '0;
              frame_busy <= 1'b0;
              par_err    <= par_flag;
              stp_err    <= stp_flag || !sampled_bit;
              if (!par_flag && !stp_flag && sampled_bit) begin
                data_out   <= shift_reg;
                data_valid <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (err_event && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// Bench for uart_rx_frame_chk: randomized frames with gaps and stray strobes, checked every
// cycle against a frame-level model of the expected end-of-frame result.
module tb_uart_rx_frame_chk;

  logic       CLK = 1'b0;
  logic       RST;
  logic       frame_start, bit_valid, sampled_bit, par_en, par_typ, err_clr;
  logic       frame_busy, strt_glitch, par_err, stp_err, data_valid;
  logic [7:0] data_out;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_data = '0;
  logic [7:0] exp_cnt  = '0;

  typedef struct {
    logic fs;
    logic bv;
    logic sb;
  } tick_t;

  uart_rx_frame_chk #(.DATA_WIDTH(8), .STOP_BITS(2), .CNT_WIDTH(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .frame_start (frame_start),
    .bit_valid   (bit_valid),
    .sampled_bit (sampled_bit),
    .par_en      (par_en),
    .par_typ     (par_typ),
    .err_clr     (err_clr),
    .frame_busy  (frame_busy),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .err_cnt     (err_cnt)
  );

  always #5 CLK = ~CLK;

  // Inputs are applied at a falling edge and outputs are sampled at the next falling edge.
  task automatic tick(input logic fs, input logic bv, input logic sb, input logic clr);
    frame_start = fs;
    bit_valid   = bv;
    sampled_bit = sb;
    err_clr     = clr;
    @(negedge CLK);
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    err_clr     = 1'b0;
  endtask

  // Drives one whole frame and compares the outputs after every cycle of it.
  task automatic send_frame(input string name, input logic start_bit, input logic [7:0] data,
                            input logic p_en, input logic p_typ, input logic p_bit,
                            input logic [1:0] stops, input int max_gap, input logic clr_last);
    logic  bits[$];
    tick_t sched[$];
    tick_t t;
    logic  glitch, perr, serr, err, good;
    logic [4:0] exp_flags, got_flags;

    bits.push_back(start_bit);
    if (!start_bit) begin
      for (int i = 0; i < 8; i++) bits.push_back(data[i]);
      if (p_en) bits.push_back(p_bit);
      bits.push_back(stops[0]);
      bits.push_back(stops[1]);
    end
    glitch = start_bit;
    perr   = !start_bit && p_en && (p_bit != ((^data) ^ p_typ));
    serr   = !start_bit && (stops != 2'b11);
    err    = glitch || perr || serr;
    good   = !err;

    t.fs = 1'b1; t.bv = 1'($urandom_range(0, 1)); t.sb = 1'($urandom_range(0, 1));
    sched.push_back(t);
    foreach (bits[i]) begin
      int gaps = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      for (int g = 0; g < gaps; g++) begin
        t.fs = ($urandom_range(0, 3) == 0); t.bv = 1'b0; t.sb = 1'($urandom_range(0, 1));
        sched.push_back(t);
      end
      t.fs = ($urandom_range(0, 3) == 0); t.bv = 1'b1; t.sb = bits[i];
      sched.push_back(t);
    end

    par_en  = p_en;
    par_typ = p_typ;
    foreach (sched[k]) begin
      logic last;
      last = (k == sched.size() - 1);
      tick(sched[k].fs, sched[k].bv, sched[k].sb, last && clr_last);
      if (k == 0) begin
        par_en  = 1'($urandom_range(0, 1));
        par_typ = 1'($urandom_range(0, 1));
      end
      if (last) begin
        if (clr_last) exp_cnt = '0;
        else if (err && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        if (good) exp_data = data;
        exp_flags = {1'b0, glitch, perr, serr, good};
      end else begin
        exp_flags = 5'b10000;
      end
      got_flags = {frame_busy, strt_glitch, par_err, stp_err, data_valid};
      n_checks++;
      if (got_flags !== exp_flags) begin
        n_fail++;
        $display("FAIL %s cycle %0d flags{busy,glitch,par,stp,valid}: got %b expected %b",
                 name, k, got_flags, exp_flags);
      end
      n_checks++;
      if (data_out !== exp_data) begin
        n_fail++;
        $display("FAIL %s cycle %0d data_out: got %h expected %h", name, k, data_out, exp_data);
      end
      n_checks++;
      if (err_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL %s cycle %0d err_cnt: got %0d expected %0d", name, k, err_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({frame_busy, strt_glitch, par_err, stp_err, data_valid, data_out, err_cnt} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b g=%b p=%b s=%b v=%b data=%h cnt=%0d expected all 0",
               frame_busy, strt_glitch, par_err, stp_err, data_valid, data_out, err_cnt);
    end
  endtask

  task automatic test_good_frame();
    send_frame("good_a5", 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 2'b11, 2, 1'b0);
  endtask

  task automatic test_parity_err();
    send_frame("parity_err_a5", 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 2'b11, 2, 1'b0);
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 6; i++) begin
      logic clr;
      clr = (i == 4);
      tick(1'b0, 1'b1, 1'($urandom_range(0, 1)), clr);
      if (clr) exp_cnt = '0;
      n_checks++;
      if ({frame_busy, strt_glitch, par_err, stp_err, data_valid} !== 5'b0 ||
          data_out !== exp_data || err_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL idle_ignore %0d: got busy=%b pulses=%b data=%h cnt=%0d expected 0/0000/%h/%0d",
                 i, frame_busy, {strt_glitch, par_err, stp_err, data_valid}, data_out, err_cnt,
                 exp_data, exp_cnt);
      end
    end
  endtask

  task automatic test_glitch();
    send_frame("glitch", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b11, 1, 1'b0);
    send_frame("after_glitch", 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 2'b11, 1, 1'b0);
  endtask

  task automatic test_stop_err();
    send_frame("stop_err_3c", 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 2'b01, 1, 1'b0);
    send_frame("stop_err_first", 1'b0, 8'hC3, 1'b1, 1'b1, 1'b1, 2'b10, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 24; f++) begin
      logic [7:0] d;
      logic       pe, pt, pb, sb0;
      logic [1:0] st;
      d   = 8'($urandom);
      pe  = 1'($urandom_range(0, 1));
      pt  = 1'($urandom_range(0, 1));
      pb  = ($urandom_range(0, 3) == 0) ? ~((^d) ^ pt) : ((^d) ^ pt);
      st  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      sb0 = ($urandom_range(0, 7) == 0);
      send_frame("back_to_back", sb0, d, pe, pt, pb, st, (f < 12) ? 0 : 3, 1'b0);
    end
  endtask

  task automatic test_saturation();
    int guard = 0;
    while (exp_cnt != 8'hFF && guard < 300) begin
      send_frame("sat_fill", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b11, 0, 1'b0);
      guard++;
    end
    send_frame("sat_hold", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b11, 0, 1'b0);
    send_frame("sat_hold_stop", 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 2'b00, 0, 1'b0);
    send_frame("clr_vs_err", 1'b0, 8'h22, 1'b1, 1'b0, 1'b1, 2'b11, 1, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    send_frame("pre_abort_err", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b11, 0, 1'b0);
    par_en  = 1'b0;
    par_typ = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    n_checks++;
    if (frame_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy_before: got %b expected 1", frame_busy);
    end
    #2 RST = 1'b1;
    #1;
    exp_data = '0;
    exp_cnt  = '0;
    n_checks++;
    if ({frame_busy, strt_glitch, par_err, stp_err, data_valid, data_out, err_cnt} !== 21'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: got busy=%b pulses=%b data=%h cnt=%0d expected all 0",
               frame_busy, {strt_glitch, par_err, stp_err, data_valid}, data_out, err_cnt);
    end
    @(negedge CLK);
    RST = 1'b0;
    send_frame("after_abort_5a", 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 2'b11, 2, 1'b0);
  endtask

  initial begin
    RST         = 1'b1;
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    sampled_bit = 1'b0;
    par_en      = 1'b0;
    par_typ     = 1'b0;
    err_clr     = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    test_reset();
    test_good_frame();
    test_parity_err();
    test_idle_ignore();
    test_glitch();
    test_stop_err();
    test_back_to_back();
    test_saturation();
    test_reset_mid_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
